riscv_fetch_unit: RTL and testbench
===================================

# riscv_fetch_unit

Parametrised instruction fetch unit with a prefetch buffer, sitting between the core's program counter logic and instruction memory. Replaces the single-cycle, combinational instruction address/data path with a pipelined req/gnt/rvalid memory handshake, several outstanding requests, and a FIFO of fetched instructions tagged with their PC. The decoder consumes instructions through a valid/ready interface. Branch and jump targets enter through a redirect port that flushes all stale fetches.

## Interface
- FIFO_DEPTH, 4: prefetch buffer entries; power of two, ≥2
- MAX_OUTSTANDING, 2: granted requests awaiting rvalid; 1..FIFO_DEPTH
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0
- clk_i  in  1  clock; all state changes on the rising edge
- arstn_i  in  1  asynchronous active-low reset
- instr_req_o  out  1  fetch request to instruction memory
- instr_addr_o  out  32  word-aligned fetch address
- instr_gnt_i  in  1  request accepted this cycle
- instr_rvalid_i  in  1  response data valid; responses arrive in request order
- instr_rdata_i  in  32  instruction word
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored, forced to 0
- fetch_valid_o  out  1  FIFO head holds a valid instruction
- fetch_instr_o  out  32  head instruction word
- fetch_pc_o  out  32  head instruction address
- fetch_ready_i  in  1  consumer accepts head this cycle

## Operation
- Registers: fetch_pc (next request address), resp_pc (address of next kept response), outstanding count, discard count, FIFO of {pc, instr}.
- Issue rule: instr_req_o=1 when outstanding + fifo_count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING, or when a request is already pending without grant.
- Once asserted, instr_req_o and instr_addr_o stay constant until instr_gnt_i, including across a redirect.
- On gnt: fetch_pc += 4 (32-bit wrap 0xFFFF_FFFC -> 0x0000_0000); outstanding += 1.
- On rvalid: outstanding -= 1. If discard > 0: discard -= 1 and drop data. Otherwise push {resp_pc, rdata}; resp_pc += 4.
- Pop: fetch_valid_o && fetch_ready_i removes the head.
- Redirect: FIFO cleared; fetch_pc = resp_pc = redirect_pc_i & ~3. Discard becomes the count of requests still in flight after this cycle, including one granted this cycle and a pending ungranted one, which is counted when granted. An rvalid in the redirect cycle is dropped.
- Simultaneous gnt and rvalid: both counters update, so outstanding is unchanged.
- Simultaneous push and pop on a full FIFO is allowed.
- redirect_i together with fetch_ready_i: redirect wins and the pop has no effect.
- rvalid with outstanding=0 is a protocol error. It is ignored and the counters do not underflow.

## Timing
- Reset values: instr_req_o=0, instr_addr_o=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=RESET_PC, FIFO empty, all counters 0.
- The first instr_req_o rises on the first clock edge after arstn_i deasserts.
- Reset asserted mid-transfer aborts everything immediately. Responses to pre-reset requests must not arrive after reset; the memory is reset from the same arstn_i.
- Default path: gnt in cycle N, rvalid at the earliest in N+1, fetch_valid_o in N+2.
- Back-to-back gnt every cycle sustains one instruction per cycle when fetch_ready_i=1 and MAX_OUTSTANDING≥2.
- Redirect in cycle N: instr_addr_o=redirect target by N+1 if no request is pending ungranted. fetch_valid_o=0 in N+1.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and discard=0, instr_rvalid_i drives fetch_valid_o combinationally. fetch_instr_o=instr_rdata_i and fetch_pc_o=resp_pc in the same cycle. If fetch_ready_i=1, the word is consumed without entering the FIFO. Default-path latency drops to N+1.
- FETCH_BYPASS_EN undefined: fetch outputs come only from FIFO registers, with no combinational path from memory inputs to fetch outputs.

## Test plan
- Streaming: memory gnt=1 always, rvalid one cycle after gnt, fetch_ready_i=1. Required: PCs 0,4,8,... delivered one per cycle; fetch_instr_o matches memory contents.
- Backpressure: fetch_ready_i=0 for 20 cycles. Required: FIFO holds 4 entries; instr_req_o=0; outstanding never exceeds 2. After release, PCs 0..0xC come out in order with none lost.
- Redirect with 2 in flight: redirect_pc_i=0x100 while outstanding=2. Required: both late responses are dropped; the next fetch_pc_o is 0x100.
- Redirect with ungranted request: instr_req_o=1, addr=0x20, gnt held 0 for 3 cycles, redirect to 0x200 in cycle 1. Required: addr stays 0x20 until gnt; that response is dropped; the next request is addr 0x200.
- Wrap and alignment: redirect_pc_i=0xFFFF_FFFE. Required: fetches at 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-stream: arstn_i=0 with 2 outstanding and FIFO half full. Required: all outputs at reset values immediately; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: pipelined req/gnt/rvalid fetch into a PC-tagged prefetch FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module riscv_fetch_unit #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        fetch_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

    logic             req_q;
    logic [31:0]      addr_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      resp_pc_q;
    logic             stale_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] discard_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];

    logic             granted;
    logic             resp_ok;
    logic             keep_resp;
    logic             drop_resp;
    logic             fifo_valid;
    logic             bypass_take;
    logic             push;
    logic             pop;
    logic             req_d;
    logic [31:0]      redirect_target;
    logic [31:0]      fetch_pc_d;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] in_use_d;

    assign redirect_target = redirect_pc_i & ~32'h3;
    assign granted         = req_q & instr_gnt_i;
    // A response with nothing in flight is a protocol error and is ignored outright.
    assign resp_ok         = instr_rvalid_i & (outstanding_q != '0);
    assign drop_resp       = resp_ok & (discard_q != '0);
    assign keep_resp       = resp_ok & (discard_q == '0) & ~redirect_i;
    assign fifo_valid      = (count_q != '0);

`ifdef FETCH_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid  = keep_resp & ~fifo_valid;
    assign bypass_take   = bypass_valid & fetch_ready_i;
    assign fetch_valid_o = fifo_valid | bypass_valid;
    assign fetch_instr_o = bypass_valid ? instr_rdata_i : fifo_instr_q[rd_ptr_q];
    assign fetch_pc_o    = bypass_valid ? resp_pc_q : fifo_pc_q[rd_ptr_q];
`else
    assign bypass_take   = 1'b0;
    assign fetch_valid_o = fifo_valid;
    assign fetch_instr_o = fifo_instr_q[rd_ptr_q];
    assign fetch_pc_o    = fifo_pc_q[rd_ptr_q];
`endif

    assign push         = keep_resp & ~bypass_take;
    assign pop          = fifo_valid & fetch_ready_i & ~redirect_i;
    assign instr_req_o  = req_q;
    assign instr_addr_o = addr_q;

    // A stale request granted after a redirect must not advance the new fetch stream.
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(granted) - CNT_W'(resp_ok);
        count_d       = redirect_i ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
        fetch_pc_d    = fetch_pc_q;
        if (redirect_i)
            fetch_pc_d = redirect_target;
        else if (granted && !stale_q)
            fetch_pc_d = fetch_pc_q + 32'd4;
        in_use_d = {1'b0, outstanding_d} + {1'b0, count_d};
        req_d    = (req_q & ~instr_gnt_i) | ((in_use_d < DEPTH_S) & (outstanding_d < MAX_C));
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            stale_q       <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= RESET_PC;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            req_q <= req_d;
            if (!req_q || instr_gnt_i)
                addr_q <= fetch_pc_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (redirect_i) begin
                // Everything still in flight after this edge is stale; an ungranted one is counted at its grant.
                resp_pc_q <= redirect_target;
                discard_q <= outstanding_d;
                stale_q   <= req_q & ~instr_gnt_i;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
            end else begin
                if (keep_resp)
                    resp_pc_q <= resp_pc_q + 32'd4;
                discard_q <= discard_q + CNT_W'(granted & stale_q) - CNT_W'(drop_resp);
                if (granted)
                    stale_q <= 1'b0;
                if (push) begin
                    fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
                    fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
                    wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: randomized memory/consumer timing against an architectural PC-stream model,
// plus directed backpressure, redirect, wrap, protocol-error and reset cases.
module tb_riscv_fetch_unit;

    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned MAX_OUTSTANDING = 2;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_ready_i;

    int          checks = 0;
    int          failures = 0;
    int          gnt_pct;
    int          rvalid_pct;
    int          ready_pct;
    int          delivered = 0;
    int          d0;
    bit          spurious_rvalid = 1'b0;
    bit          hold_req = 1'b0;
    bit          expect_invalid = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic [31:0] mem_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] pc_log[$];

    riscv_fetch_unit #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk_i),
        .arstn_i(arstn_i),
        .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o(fetch_pc_o),
        .fetch_ready_i(fetch_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] log_get(input logic [31:0] q[$], input int idx);
        if (idx < q.size())
            return q[idx];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive memory/consumer, observe at posedge+2, then advance to the next posedge+1.
    task automatic applyStimulus(input bit do_redirect, input logic [31:0] target);
        logic [31:0] a;
        instr_gnt_i = (int'($urandom_range(99)) < gnt_pct);
        if (mem_q.size() > 0 && int'($urandom_range(99)) < rvalid_pct) begin
            a              = mem_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(a);
        end else if (spurious_rvalid && mem_q.size() == 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = 32'hDEAD_BEEF;
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
        fetch_ready_i = (int'($urandom_range(99)) < ready_pct);
        redirect_i    = do_redirect;
        redirect_pc_i = target;
        #1;
        if (expect_invalid)
            checkOutput("valid_after_redirect", 32'(fetch_valid_o), 32'd0);
        expect_invalid = do_redirect;
        if (hold_req) begin
            checkOutput("req_held", 32'(instr_req_o), 32'd1);
            checkOutput("addr_held", instr_addr_o, held_addr);
        end
        hold_req  = instr_req_o && !instr_gnt_i;
        held_addr = instr_addr_o;
        if (instr_req_o && instr_gnt_i) begin
            mem_q.push_back(instr_addr_o);
            grant_log.push_back(instr_addr_o);
            checkOutput("outstanding_limit", 32'(mem_q.size() <= MAX_OUTSTANDING), 32'd1);
        end
        if (fetch_valid_o && fetch_ready_i && !do_redirect) begin
            checkOutput("fetch_pc", fetch_pc_o, exp_pc);
            checkOutput("fetch_instr", fetch_instr_o, mem_word(exp_pc));
            pc_log.push_back(fetch_pc_o);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (do_redirect) begin
            exp_pc = target & ~32'h3;
            pc_log.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arstn_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        redirect_i     = 1'b0;
        redirect_pc_i  = '0;
        fetch_ready_i  = 1'b0;
        exp_pc         = RESET_PC;

        // Reset values, then the first request on the first edge after release.
        #3;
        checkOutput("rst_req", 32'(instr_req_o), 32'd0);
        checkOutput("rst_addr", instr_addr_o, RESET_PC);
        checkOutput("rst_valid", 32'(fetch_valid_o), 32'd0);
        checkOutput("rst_instr", fetch_instr_o, 32'd0);
        checkOutput("rst_pc", fetch_pc_o, RESET_PC);
        #9;
        arstn_i = 1'b1;
        #1;
        checkOutput("req_before_edge", 32'(instr_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("first_req", 32'(instr_req_o), 32'd1);
        checkOutput("first_addr", instr_addr_o, RESET_PC);

        // Streaming at full rate.
        gnt_pct = 100; rvalid_pct = 100; ready_pct = 100;
        d0 = delivered;
        repeat (30) applyStimulus(1'b0, 32'h0);
        checkOutput("stream_rate", 32'((delivered - d0) >= 28), 32'd1);
        checkOutput("stream_first_pc", log_get(pc_log, 0), RESET_PC);

        // Backpressure fills the FIFO and stops requests.
        ready_pct = 0;
        repeat (20) applyStimulus(1'b0, 32'h0);
        checkOutput("bp_req_idle", 32'(instr_req_o), 32'd0);
        checkOutput("bp_valid", 32'(fetch_valid_o), 32'd1);
        gnt_pct = 0; ready_pct = 100;
        d0 = delivered;
        repeat (6) applyStimulus(1'b0, 32'h0);
        checkOutput("bp_fifo_entries", 32'(delivered - d0), 32'(FIFO_DEPTH));

        // Redirect while a request is pending without grant.
        checkOutput("pend_req", 32'(instr_req_o), 32'd1);
        pend_addr = instr_addr_o;
        applyStimulus(1'b1, 32'h0000_0200);
        checkOutput("pend_req_kept", 32'(instr_req_o), 32'd1);
        checkOutput("pend_addr_kept", instr_addr_o, pend_addr);
        repeat (2) applyStimulus(1'b0, 32'h0);
        grant_log.delete();
        gnt_pct = 100; rvalid_pct = 100;
        repeat (10) applyStimulus(1'b0, 32'h0);
        checkOutput("stale_grant_addr", log_get(grant_log, 0), pend_addr);
        checkOutput("post_redirect_addr", log_get(grant_log, 1), 32'h0000_0200);
        checkOutput("pend_first_pc", log_get(pc_log, 0), 32'h0000_0200);

        // Redirect with two requests in flight; one response lands in the redirect cycle.
        rvalid_pct = 0;
        repeat (2) applyStimulus(1'b0, 32'h0);
        checkOutput("inflight_req_idle", 32'(instr_req_o), 32'd0);
        rvalid_pct = 100;
        applyStimulus(1'b1, 32'h0000_0100);
        repeat (10) applyStimulus(1'b0, 32'h0);
        checkOutput("inflight_first_pc", log_get(pc_log, 0), 32'h0000_0100);

        // Unaligned target near the top of the address space wraps to zero.
        applyStimulus(1'b1, 32'hFFFF_FFFE);
        repeat (10) applyStimulus(1'b0, 32'h0);
        checkOutput("wrap_pc0", log_get(pc_log, 0), 32'hFFFF_FFFC);
        checkOutput("wrap_pc1", log_get(pc_log, 1), 32'h0000_0000);

        // A response with nothing outstanding must be ignored.
        gnt_pct = 0;
        repeat (5) applyStimulus(1'b0, 32'h0);
        spurious_rvalid = 1'b1;
        applyStimulus(1'b0, 32'h0);
        spurious_rvalid = 1'b0;
        gnt_pct = 100;
        d0 = delivered;
        repeat (10) applyStimulus(1'b0, 32'h0);
        checkOutput("spurious_progress", 32'((delivered - d0) >= 5), 32'd1);

        // Random memory latency, consumer stalls and redirects.
        d0 = delivered;
        for (int blk = 0; blk < 16; blk++) begin
            gnt_pct    = int'($urandom_range(100, 40));
            rvalid_pct = int'($urandom_range(100, 40));
            ready_pct  = int'($urandom_range(100, 40));
            for (int c = 0; c < 50; c++)
                applyStimulus(int'($urandom_range(99)) < 3, $urandom);
        end
        checkOutput("random_progress", 32'((delivered - d0) >= 50), 32'd1);

        // Reset mid-stream with requests in flight and FIFO partly full.
        gnt_pct = 100; rvalid_pct = 100; ready_pct = 0;
        applyStimulus(1'b1, 32'h0000_0040);
        repeat (3) applyStimulus(1'b0, 32'h0);
        rvalid_pct = 0;
        repeat (2) applyStimulus(1'b0, 32'h0);
        arstn_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        fetch_ready_i  = 1'b0;
        redirect_i     = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(instr_req_o), 32'd0);
        checkOutput("mid_rst_addr", instr_addr_o, RESET_PC);
        checkOutput("mid_rst_valid", 32'(fetch_valid_o), 32'd0);
        checkOutput("mid_rst_instr", fetch_instr_o, 32'd0);
        checkOutput("mid_rst_pc", fetch_pc_o, RESET_PC);
        mem_q.delete();
        pc_log.delete();
        hold_req       = 1'b0;
        expect_invalid = 1'b0;
        exp_pc         = RESET_PC;
        @(posedge clk_i);
        #3;
        arstn_i = 1'b1;
        #1;
        checkOutput("mid_req_before_edge", 32'(instr_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("mid_first_req", 32'(instr_req_o), 32'd1);
        checkOutput("mid_first_addr", instr_addr_o, RESET_PC);
        gnt_pct = 100; rvalid_pct = 100; ready_pct = 100;
        repeat (10) applyStimulus(1'b0, 32'h0);
        checkOutput("mid_first_pc", log_get(pc_log, 0), RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
